// File: rtl/vertex_primitive_assembler.sv
// Vertex primitive assembler: collects x/y/z coordinate words from the matrix
// processor, applies the viewport transform to x/y, groups three vertices into
// a triangle and queues triangles for the rasteriser behind a valid/ready port.
module vertex_primitive_assembler #(
  parameter int DATA_W    = 16,
  parameter int FRAC      = 8,
  parameter int SCREEN_W  = 64,
  parameter int SCREEN_H  = 64,
  parameter int XY_W      = 6,
  parameter int TRI_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  input  logic signed [DATA_W-1:0]            in_data,
  input  logic                                flush,
  output logic                                accept_vtx,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [3*(2*XY_W+DATA_W)-1:0]        out_tri,
  output logic [$clog2(TRI_DEPTH):0]          fifo_count,
  output logic                                overflow
);

  localparam int VTX_W = 2*XY_W + DATA_W;
  localparam int TRI_W = 3*VTX_W;
  localparam int PTR_W = $clog2(TRI_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EXT_W = DATA_W + XY_W + 1;
  localparam int ONE   = 1 << FRAC;

  // Which coordinate of the current vertex the next beat carries.
  typedef enum logic [1:0] {COMP_X, COMP_Y, COMP_Z} comp_e;

  comp_e             comp_q, comp_d;
  logic [1:0]        vtx_q, vtx_d;
  logic [XY_W-1:0]   sx_q, sy_q;
  logic [VTX_W-1:0]  v0_q, v1_q;
  logic [VTX_W-1:0]  cur_vtx;

  logic [TRI_W-1:0]  mem [TRI_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;

  logic beat, full, pop, push_req, push;

  // Map a normalised coordinate in [-ONE, ONE] onto 0..s-1, clamping outside.
  function automatic logic [XY_W-1:0] viewport(input logic signed [DATA_W-1:0] c,
                                                input int s);
    logic signed [EXT_W-1:0] t;
    logic [XY_W-1:0]         res;
    t = ((EXT_W'(c) + EXT_W'(ONE)) * EXT_W'(s / 2)) >>> FRAC;
    if (t[EXT_W-1])             res = '0;
    else if (t >= EXT_W'(s))    res = XY_W'(s - 1);
    else                        res = t[XY_W-1:0];
    return res;
  endfunction

  // A flushed beat is dropped entirely, so only unflushed beats move state.
  assign beat     = in_valid && !flush;
  assign cur_vtx  = {in_data, sy_q, sx_q};
  assign full     = (count_q == CNT_W'(TRI_DEPTH));
  assign out_valid = (count_q != '0);
  assign pop      = out_valid && out_ready;
  assign push_req = beat && (comp_q == COMP_Z) && (vtx_q == 2'd2);
  // A completing triangle still lands when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);

  assign out_tri    = mem[rd_q];
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  // Stall the upstream only before the x beat of a v2 that would be dropped.
  assign accept_vtx = !((vtx_q == 2'd2) && (comp_q == COMP_X) && full && !pop);

  // Next-state logic for the coordinate/vertex position counters.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    comp_d = comp_q;
    vtx_d  = vtx_q;
    if (flush) begin
      comp_d = COMP_X;
      vtx_d  = '0;
    end else if (in_valid) begin
      unique case (comp_q)
        COMP_X:  comp_d = COMP_Y;
        COMP_Y:  comp_d = COMP_Z;
        default: begin
          comp_d = COMP_X;
          vtx_d  = (vtx_q == 2'd2) ? 2'd0 : vtx_q + 2'd1;
        end
      endcase
    end
  end

  // Position counter registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      comp_q <= COMP_X;
      vtx_q  <= '0;
    end else begin
      comp_q <= comp_d;
      vtx_q  <= vtx_d;
    end
  end

  // Capture screen x/y at their beats and latch finished v0/v1 on z.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sx_q <= '0;
      sy_q <= '0;
      v0_q <= '0;
      v1_q <= '0;
    end else if (beat) begin
      unique case (comp_q)
        COMP_X: sx_q <= viewport(in_data, SCREEN_W);
        COMP_Y: sy_q <= XY_W'(SCREEN_H - 1) - viewport(in_data, SCREEN_H);
        default: begin
          if (vtx_q == 2'd0)      v0_q <= cur_vtx;
          else if (vtx_q == 2'd1) v1_q <= cur_vtx;
        end
      endcase
    end
  end

  // Triangle FIFO: storage, pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the storage is tiny and is the output head, so it is cleared to give out_tri=0 after reset.
      for (int i = 0; i < TRI_DEPTH; i++) mem[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_q] <= {cur_vtx, v1_q, v0_q};
        wr_q      <= wr_q + PTR_W'(1);
      end
      if (pop) rd_q <= rd_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
      if (push_req && full && !pop) ovf_q <= 1'b1;
    end
  end

endmodule
